// File: rtl/mux_rr_sequencer_if.sv
// Handshake bundle between the round-robin sequencer and its neighbours.
// Carries source req/ack, mux sel/data and the valid/ready output stream.
interface mux_rr_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [3:0]       ack;
  logic [1:0]       sel;
  logic [WIDTH-1:0] mux_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport slave (
    input  req,
    input  mux_in,
    input  out_ready,
    output ack,
    output sel,
    output out_data,
    output out_valid,
    output busy
  );

  modport master (
    output req,
    output mux_in,
    output out_ready,
    input  ack,
    input  sel,
    input  out_data,
    input  out_valid,
    input  busy
  );
endinterface

// File: rtl/mux_rr_sequencer.sv
// Round-robin sequencer driving a 4:1 mux select and capturing its output.
// Ports: clk, rst (async high), bus (req/ack, sel/mux_in, out valid/ready, busy).
module mux_rr_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  mux_rr_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    HOLD
  } state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       sel, sel_n;
  logic [WIDTH-1:0] data, data_n;
  logic             valid, valid_n;

  // First requester at or after p, wrapping modulo 4.
  function automatic logic [1:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      sel   <= sel_n;
      data  <= data_n;
      valid <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    data_n  = data;
    valid_n = valid;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          sel_n   = pick(bus.req, ptr);
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        data_n  = bus.mux_in;
        valid_n = 1'b1;
        ptr_n   = sel + 2'd1;
        state_n = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          valid_n = 1'b0;
          if (|bus.req) begin
            // ptr already advanced past the previous grant
            sel_n   = pick(bus.req, ptr);
            state_n = SAMPLE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ack comes only from registered state, so it cannot glitch
  assign bus.ack       = (state == SAMPLE) ? (4'b0001 << sel) : 4'b0000;
  assign bus.sel       = sel;
  assign bus.out_data  = data;
  assign bus.out_valid = valid;
  assign bus.busy      = (state != IDLE);

endmodule

// File: doc/mux_rr_sequencer.md
Name: mux_rr_sequencer

Overview:
- Round-robin sequencer that sits directly upstream of the 4:1 word mux (mux_4to1).
- Arbitrates four requesting sources, drives the mux select, and samples the mux output one cycle later.
- Presents the selected word on a registered valid/ready output and returns a one-cycle ack to the granted source.
- Gives fair, glitch-free time-division sharing of the mux by four producers.

Parameters:
WIDTH, 4, data width of each mux input and of mux_in/out_data.

Ports:
clk  input  1  single clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  4  req[i] high = source i has a word on mux input i (a=0, b=1, c=2, d=3).
ack  output  4  one-hot, one-cycle pulse; word from source i captured this cycle.
sel  output  2  registered select to mux_4to1.sel.
mux_in  input  WIDTH  connected to mux_4to1.out.
out_data  output  WIDTH  captured word.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts when high with out_valid.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate, independent of clk):
  - sel=00, ack=0000, out_data=0, out_valid=0, busy=0.
  - State=IDLE; round-robin pointer ptr=0, so source 0 has top priority first.
- ptr: 2-bit, next candidate. After a grant to source g, ptr=g+1 mod 4 (3 wraps to 0).
- Winner: first i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
- IDLE:
  - If req=0000, stay; sel holds its last value.
  - Otherwise, at the clock edge: sel<=winner, go SAMPLE.
- SAMPLE (exactly one cycle; sel stable so the combinational mux settles):
  - ack[sel]=1, all other ack bits 0. ack is decoded from registered state and sel, so it is glitch-free.
  - At the clock edge ending SAMPLE: out_data<=mux_in, out_valid<=1, ptr<=sel+1, go HOLD.
- HOLD:
  - out_valid=1; out_data and sel stable; ack=0000.
  - If out_ready=0, stay; nothing changes.
  - If out_ready=1 (transfer), at that edge:
    - If any req, compute winner with the updated ptr, sel<=winner, out_valid<=0, go SAMPLE.
    - Else out_valid<=0, go IDLE.
- Latency:
  - req seen in IDLE at cycle N: sel changes at N+1, ack high during N+1, out_valid from N+2.
  - With all req high and out_ready held high, one word every 2 cycles.
- Source contract:
  - Hold req and data stable until the ack cycle ends; may change data/req at the edge after ack.
  - A req dropped during SAMPLE is ignored; the grant is committed and the word is captured.
- A req that rises while in HOLD is considered only at the transfer edge or on return to IDLE; no preemption.
- Simultaneous requests resolve only via ptr; there is no fixed priority after reset.
- Reset asserted mid-SAMPLE or mid-HOLD drops ack/out_valid immediately; the captured word is discarded.

Test Plan:
1. Drive mux data a=0100, b=1010, c=0011, d=1100; req=1111, out_ready=1 after reset -> ack pulses 0,1,2,3,0 and out_data 0100,1010,0011,1100,0100; out_valid high every other cycle; sel 00,01,10,11,00.
2. req=0100 only, from IDLE at cycle N -> sel=10 at N+1, ack=0100 during N+1 only, out_data=0011 with out_valid at N+2; after a transfer with req=0, state returns to IDLE and busy=0.
3. Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 with out_data=1010 -> out_data, sel=01 and out_valid held, ack=0000 throughout; out_ready=1 -> single transfer, next grant is 2 (req=1111).
4. Fairness and wrap: req=1001 held -> grants alternate 0,3,0,3; ptr wraps from 3 to 0 with no double grant to either source.
5. Async reset pulse mid-HOLD, between clock edges -> out_valid, ack and sel go 0 immediately. After release with req=0010, first grant is 1; with req=1111, first grant is 0.
6. req=0000 for 10 cycles after reset -> busy=0, out_valid=0, ack=0000, sel unchanged.
